alu_exec_unit: RTL

Multi-cycle execute stage that sits directly downstream of the ALU controller. It consumes the 4-bit `Operation` code and two 32-bit operands, and returns a registered result plus branch-compare flags through a start/done handshake. Logic ops, arithmetic and compares finish in one cycle. Shifts run iteratively, one bit position per cycle, so no 32-bit barrel shifter is needed on the FPGA build.

---
 rtl/alu_exec_if.sv | 25 ++
 rtl/alu_exec_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_if.sv
// Start/done handshake bundle between the ALU controller and the execute stage.
interface alu_exec_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [3:0]      Operation;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] ALUResult;
    logic            Zero;
    logic            LessS;
    logic            LessU;

    modport master (
        output start, Operation, SrcA, SrcB,
        input  busy, done, ALUResult, Zero, LessS, LessU
    );

    modport slave (
        input  start, Operation, SrcA, SrcB,
        output busy, done, ALUResult, Zero, LessS, LessU
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute stage: single-cycle logic/arith/compare, shifts iterate one bit per cycle.
module alu_exec_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic      clk,
    input  logic      reset,
    alu_exec_if.slave alu_if
);
    localparam int unsigned SHAMT_W = 5;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SUBU = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1100;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

    state_e              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [XLEN-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic                pend_s_q, pend_s_d;
    logic                pend_u_q, pend_u_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                zero_q, zero_d;
    logic                less_s_q, less_s_d;
    logic                less_u_q, less_u_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                in_shift;
    logic [SHAMT_W-1:0]  shamt;
    logic                lt_s, lt_u;
    logic [XLEN-1:0]     alu_res;
    logic [XLEN-1:0]     shifted;

    assign in_shift = (alu_if.Operation == OP_SLL) || (alu_if.Operation == OP_SRL) ||
                      (alu_if.Operation == OP_SRA);
    assign shamt    = alu_if.SrcB[SHAMT_W-1:0];
    assign lt_s     = $signed(alu_if.SrcA) < $signed(alu_if.SrcB);
    assign lt_u     = alu_if.SrcA < alu_if.SrcB;

    // Single-cycle result; a shift only lands here with a zero amount, so it passes A through.
    always_comb begin
        alu_res = '0;
        case (alu_if.Operation)
            OP_AND:                 alu_res = alu_if.SrcA & alu_if.SrcB;
            OP_OR:                  alu_res = alu_if.SrcA | alu_if.SrcB;
            OP_ADD:                 alu_res = alu_if.SrcA + alu_if.SrcB;
            OP_XOR:                 alu_res = alu_if.SrcA ^ alu_if.SrcB;
            OP_SUB, OP_SUBU:        alu_res = alu_if.SrcA - alu_if.SrcB;
            OP_SLTU:                alu_res = XLEN'(lt_u);
            OP_SLT:                 alu_res = XLEN'(lt_s);
            OP_SLL, OP_SRL, OP_SRA: alu_res = alu_if.SrcA;
            default:                alu_res = '0;
        endcase
    end

    // One bit position per cycle on the working register.
    always_comb begin
        case (op_q)
            OP_SLL:  shifted = {work_q[XLEN-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work_q[XLEN-1:1]};
            default: shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (alu_if.start) state_d = (in_shift && shamt != '0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        pend_s_d = pend_s_q;
        pend_u_d = pend_u_q;
        result_d = result_q;
        zero_d   = zero_q;
        less_s_d = less_s_q;
        less_u_d = less_u_q;
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (alu_if.start) begin
                    op_d     = alu_if.Operation;
                    work_d   = alu_if.SrcA;
                    cnt_d    = shamt;
                    pend_s_d = lt_s;
                    pend_u_d = lt_u;
                    if (!(in_shift && shamt != '0)) begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        less_s_d = lt_s;
                        less_u_d = lt_u;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                    less_s_d = pend_s_q;
                    less_u_d = pend_u_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            pend_s_q <= 1'b0;
            pend_u_q <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            less_s_q <= 1'b0;
            less_u_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            pend_s_q <= pend_s_d;
            pend_u_q <= pend_u_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            less_s_q <= less_s_d;
            less_u_q <= less_u_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign alu_if.busy      = busy_q;
    assign alu_if.done      = done_q;
    assign alu_if.ALUResult = result_q;
    assign alu_if.Zero      = zero_q;
    assign alu_if.LessS     = less_s_q;
    assign alu_if.LessU     = less_u_q;
endmodule
